bisr_remap_mux_pipe: RTL

Registered, pipelined N-to-M word remapper for the weight-proxy BISR path. Each of NUM_OUTPUTS lanes independently selects one of NUM_INPUTS words (e.g. steering a faulty PE's weight to a spare column). Select codes are written into a shadow table and committed atomically at a burst boundary, so a data burst is never split across two mappings. A timeout forces the commit if no gap appears.

---
 rtl/bisr_remap_mux_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bisr_remap_mux_pipe.sv
// BISR weight remapper: each output lane picks one input word; select table committed atomically at burst gaps.
// Latency PIPE_STAGES cycles, 1 beat/cycle, no backpressure (commit waits for an in_valid gap or COMMIT_TIMEOUT).
module bisr_remap_mux_pipe #(
    parameter int NUM_INPUTS     = 4,
    parameter int NUM_OUTPUTS    = 4,
    parameter int WORD_SIZE      = 16,
    parameter int PIPE_STAGES    = 2,
    parameter int COMMIT_TIMEOUT = 64,
    localparam int SEL_W  = $clog2(NUM_INPUTS),
    localparam int LANE_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [NUM_INPUTS*WORD_SIZE-1:0]  in_bus,
    output logic                             out_valid,
    output logic [NUM_OUTPUTS*WORD_SIZE-1:0] out_bus,
    input  logic                             cfg_wr_en,
    input  logic [LANE_W-1:0]                cfg_lane,
    input  logic [SEL_W-1:0]                 cfg_sel,
    input  logic                             cfg_commit,
    output logic                             cfg_busy,
    output logic [NUM_OUTPUTS*SEL_W-1:0]     active_sel_bus,
    output logic                             sel_err
);
    localparam int CNT_W = $clog2(COMMIT_TIMEOUT + 1);
    localparam int BUS_W = NUM_OUTPUTS * WORD_SIZE;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   shadow_q [NUM_OUTPUTS];
    logic [SEL_W-1:0]   shadow_d [NUM_OUTPUTS];
    logic [SEL_W-1:0]   active_q [NUM_OUTPUTS];
    logic [SEL_W-1:0]   active_d [NUM_OUTPUTS];
    logic               sel_err_q, sel_err_d;
    logic               vld_q [PIPE_STAGES];
    logic [BUS_W-1:0]   dat_q [PIPE_STAGES];
    logic [BUS_W-1:0]   mux_dat;
    logic               lane_ok, sel_ok, wr_ok, do_copy;

    always_comb begin
        lane_ok   = int'(cfg_lane) < NUM_OUTPUTS;
        sel_ok    = int'(cfg_sel) < NUM_INPUTS;
        wr_ok     = cfg_wr_en && (state_q == IDLE) && lane_ok && sel_ok;
        sel_err_d = sel_err_q | (cfg_wr_en & ~wr_ok);
        shadow_d  = shadow_q;
        if (wr_ok) begin
            shadow_d[cfg_lane] = cfg_sel;
        end
    end

    // The copy takes shadow_d so a same-cycle write is included in the commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_copy = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_commit) begin
                    if (in_valid) begin
                        state_d = PENDING;
                        cnt_d   = '0;
                    end else begin
                        do_copy = 1'b1;
                    end
                end
            end
            PENDING: begin
                cnt_d = cnt_q + 1'b1;
                if (!in_valid || cnt_q == CNT_W'(COMMIT_TIMEOUT - 1)) begin
                    do_copy = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = do_copy ? shadow_d : active_q;
    end

    // Compare-based mux keeps non-power-of-two NUM_INPUTS free of out-of-range slices.
    always_comb begin
        mux_dat = '0;
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (active_q[j] == SEL_W'(i)) begin
                    mux_dat[j*WORD_SIZE +: WORD_SIZE] = in_bus[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
            for (int j = 0; j < NUM_OUTPUTS; j++) begin
                shadow_q[j] <= SEL_W'(j % NUM_INPUTS);
                active_q[j] <= SEL_W'(j % NUM_INPUTS);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_err_q <= sel_err_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                vld_q[k] <= 1'b0;
                dat_q[k] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                dat_q[0] <= mux_dat;
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
            active_sel_bus[j*SEL_W +: SEL_W] = active_q[j];
        end
    end

    assign out_valid = vld_q[PIPE_STAGES-1];
    assign out_bus   = dat_q[PIPE_STAGES-1];
    assign cfg_busy  = (state_q == PENDING);
    assign sel_err   = sel_err_q;
endmodule
